// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and the round-robin search helper
// used by the FIFO push-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned MAX_IDW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] index;
  } pick_t;

  // First set bit of valid, scanning start, start+1, ...
  // modulo num_req. start must be below num_req.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input int unsigned        start,
    input int unsigned        num_req
  );
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = start + k;
      if (idx >= num_req) begin
        idx = idx - num_req;
      end
      if ((k < num_req) && !r.found) begin
        if (valid[idx[MAX_IDW-1:0]]) begin
          r.found = 1'b1;
          r.index = idx[MAX_IDW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_picker.sv
// rr_priority_picker: combinational round-robin search
// over a request vector from a given start index.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     start_i,
  output logic               found_o,
  output logic [IDW-1:0]     index_o
);

  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;

  // Widen to the helper's fixed width and run the search
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = valid_i;
    pick = rr_pick(valid_ext, 32'(start_i), NUM_REQ);
    found_o = pick.found;
    index_o = IDW'(pick.index);
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin arbiter sharing one FIFO push port
// among NUM_REQ valid/ready requesters, bounded bursts per grant.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 3,
  parameter int unsigned IDW        =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          push,
  output logic [FIFO_WIDTH-1:0]         push_data,
  output logic                          grant_valid,
  output logic [IDW-1:0]                grant_id
);

  localparam int unsigned CW =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

  logic                  in_grant;
  logic                  owner_valid;
  logic [FIFO_WIDTH-1:0] owner_data;
  logic                  port_open;
  logic                  xfer;
  logic                  last_beat;
  logic                  release_grant;
  logic [IDW-1:0]        id_next;
  logic [IDW-1:0]        pick_start;
  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;

  assign in_grant  = (state_q == GRANT);
  assign port_open = in_grant & ~fifo_full & ~rst;
  assign xfer      = port_open & owner_valid;
  assign last_beat = (burst_cnt_q == LAST_BEAT);

  // The owner gives up the port after its final beat,
  // or at once if it stops presenting data.
  assign release_grant =
    in_grant & (~owner_valid | (xfer & last_beat));

  // Successor index wraps at NUM_REQ, not at 2**IDW
  assign id_next =
    (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);

  // Idle searches from the pointer; a releasing owner
  // searches from its successor so it is considered last.
  assign pick_start = in_grant ? id_next : rr_ptr_q;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .valid_i (req_valid),
    .start_i (pick_start),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  // Select the current owner's valid bit and data word
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next grant, pointer and burst count
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          rr_ptr_d    = id_next;
          burst_cnt_d = '0;
          if (pick_found) begin
            grant_id_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port-facing outputs; nothing moves while in reset
  always_comb begin
    push        = xfer;
    push_data   = owner_data;
    grant_valid = in_grant;
    grant_id    = grant_id_q;
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = port_open & (grant_id_q == IDW'(i));
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: randomized and directed stimulus,
// reference model feeding a scoreboard checked by a monitor.
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BL = 3;
  localparam int MAXW = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           push;
  logic [W-1:0]   push_data;
  logic           grant_valid;
  logic [1:0]     grant_id;

  fifo_push_arbiter #(
    .NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(BL)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .push(push), .push_data(push_data),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // Second instance: 3 requesters, single-beat bursts
  logic        rst3 = 1'b1;
  logic [2:0]  rv3 = '0;
  logic [23:0] rd3 = {8'hA2, 8'hA1, 8'hA0};
  logic [2:0]  rdy3;
  logic        push3;
  logic [7:0]  pd3;
  logic        gv3;
  logic [1:0]  gid3;
  bit          done3 = 1'b0;

  fifo_push_arbiter #(
    .NUM_REQ(3), .FIFO_WIDTH(8), .BURST_LEN(1)
  ) u_dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(rv3), .req_data(rd3),
    .req_ready(rdy3), .fifo_full(1'b0),
    .push(push3), .push_data(pd3),
    .grant_valid(gv3), .grant_id(gid3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endtask

  // Per-requester word streams
  logic [W-1:0] words [N][MAXW];
  int wcnt [N];
  int drv_ptr [N];
  int mdl_ptr [N];
  int gap_pct = 0;
  logic [N-1:0] hs = '0;

  task automatic add_words(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      if (wcnt[i] < MAXW) begin
        words[i][wcnt[i]] = W'($urandom);
        wcnt[i]++;
      end
    end
  endtask

  // Requester driver: hold valid/data until accepted
  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) drv_ptr[i]++;
      if (!(req_valid[i] && !hs[i])) begin
        req_valid[i] = (drv_ptr[i] < wcnt[i]) &&
          (int'($urandom_range(99)) >= gap_pct);
      end
      req_data[i*W +: W] = (drv_ptr[i] < wcnt[i]) ?
        words[i][drv_ptr[i]] : '0;
    end
  end

  // Reference model: owner, beats taken, search pointer
  typedef struct {
    int           id;
    logic [W-1:0] data;
  } item_t;
  item_t exp_q[$];
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  logic [N-1:0]   pend = '0;
  logic [N*W-1:0] pdata = '0;

  function automatic int pick(input logic [N-1:0] v,
                              input int start);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    bit           xfer;
    logic [N-1:0] exp_rdy;
    item_t        it;
    hs = req_valid & req_ready;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && (!req_valid[i] ||
          req_data[i*W +: W] != pdata[i*W +: W]))
        $error("requester %0d broke hold rule", i);
    end
    pend  = req_valid & ~hs;
    pdata = req_data;
    xfer = !rst && (m_owner >= 0) && !fifo_full &&
           req_valid[m_owner];
    exp_rdy = '0;
    if (!rst && (m_owner >= 0) && !fifo_full)
      exp_rdy[m_owner] = 1'b1;
    chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    if (m_owner >= 0)
      chk("grant_id", 32'(grant_id), m_owner);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("push", 32'(push), 32'(xfer));
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    if (xfer && mdl_ptr[m_owner] < MAXW) begin
      it.id   = m_owner;
      it.data = words[m_owner][mdl_ptr[m_owner]];
      exp_q.push_back(it);
      mdl_ptr[m_owner]++;
    end
    if (rst) begin
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(req_valid, m_ptr);
      m_cnt   = 0;
    end else if (!req_valid[m_owner] ||
                 (xfer && m_cnt == BL - 1)) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = pick(req_valid, m_ptr);
      m_cnt   = 0;
    end else if (xfer) begin
      m_cnt++;
    end
  end

  // Monitor: every push must match the next expected word
  always begin
    item_t it;
    @(negedge clk);
    #1;
    if (push === 1'b1) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
      chk("push_not_full", 32'(fifo_full), 0);
      if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        chk("push_id", 32'(grant_id), it.id);
        chk("push_data", 32'(push_data), 32'(it.data));
      end
    end
  end

  task automatic wait_owner(input int o, input int c);
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      @(posedge clk);
      #1;
      if (m_owner == o && (c < 0 || m_cnt == c)) hit = 1'b1;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_owner o=%0d c=%0d timed out", o, c);
    end
  endtask

  task automatic drain(input string nm);
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 3000 && !idle; t++) begin
      @(posedge clk);
      #1;
      idle = (exp_q.size() == 0) && (m_owner < 0);
      for (int i = 0; i < N; i++)
        if (drv_ptr[i] != wcnt[i]) idle = 1'b0;
    end
    chk({nm, "_drained"}, 32'(idle), 1);
    for (int i = 0; i < N; i++)
      chk({nm, "_count"}, mdl_ptr[i], wcnt[i]);
  endtask

  // Directed scenarios followed by a randomized soak
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    add_words(0, 7);
    drain("single");

    for (int i = 0; i < N; i++) add_words(i, 12);
    drain("all4");

    add_words(2, 5);
    wait_owner(2, 1);
    add_words(3, 3);
    fifo_full = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fifo_full = 1'b0;
    drain("backpressure");

    add_words(1, 1);
    wait_owner(1, -1);
    add_words(0, 3);
    add_words(3, 3);
    drain("early_release");

    add_words(2, 6);
    wait_owner(2, 1);
    add_words(0, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain("mid_reset");

    gap_pct = 30;
    for (int t = 0; t < 1500; t++) begin
      @(posedge clk);
      #1;
      fifo_full = ($urandom_range(99) < 20);
      for (int i = 0; i < N; i++)
        if (wcnt[i] - drv_ptr[i] < 2 && wcnt[i] < MAXW - 8)
          add_words(i, int'($urandom_range(5, 1)));
    end
    fifo_full = 1'b0;
    gap_pct = 0;
    drain("random");

    for (int t = 0; t < 200 && !done3; t++) @(posedge clk);
    chk("r3_done", 32'(done3), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // NUM_REQ=3, BURST_LEN=1: rotation 0,1,2,0,1,2
  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b0;
    rv3  = 3'b111;
    w = 0;
    @(negedge clk);
    while (push3 !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("r3_first_push", 32'(push3), 1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("r3_push", 32'(push3), 1);
      chk("r3_gid", 32'(gid3), k % 3);
      chk("r3_data", 32'(pd3), 32'(8'hA0 + k % 3));
      chk("r3_rdy", 32'(rdy3), 32'(1 << (k % 3)));
    end
    done3 = 1'b1;
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares one FIFO push port among NUM_REQ requesters.
- Each requester uses a valid/ready handshake.
- Round-robin arbitration; one requester holds the grant for a burst of at most BURST_LEN transfers.
- Sits in front of the parameterised FIFO and drives its push/push_data, backpressured by its full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..16, need not be a power of two)
- FIFO_WIDTH, 8, data width per requester and of push_data
- BURST_LEN, 3, maximum consecutive transfers per grant (>=1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*FIFO_WIDTH  requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- fifo_full  in  1  full flag from the FIFO
- push  out  1  FIFO push strobe
- push_data  out  FIFO_WIDTH  FIFO write data
- grant_valid  out  1  a requester currently owns the port
- grant_id  out  max(1,$clog2(NUM_REQ))  current owner index

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, grant_valid=0, grant_id=0, rr_ptr=0, burst_cnt=0. push=0 and req_ready=0 in the same cycle.
- States:
  - IDLE: no owner.
  - GRANT: owner = grant_id.
- Picker: the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- IDLE:
  - If any req_valid, go to GRANT next cycle with grant_id=pick and burst_cnt=0.
  - One-cycle arbitration latency. No transfer occurs in IDLE.
- GRANT outputs, all combinational:
  - req_ready[grant_id] = ~fifo_full; all other req_ready = 0.
  - push = req_valid[grant_id] & ~fifo_full.
  - push_data = req_data slice of grant_id.
  - A transfer occurs when push=1.
- GRANT release conditions:
  - (a) transfer with burst_cnt==BURST_LEN-1;
  - (b) req_valid[grant_id]=0 (no transfer that cycle).
- On release:
  - rr_ptr <= (grant_id+1) mod NUM_REQ.
  - Re-pick from the current req_valid, starting at grant_id+1. Search order excludes nothing, so the owner is considered last.
  - If there is a winner: stay in GRANT, new grant_id, burst_cnt=0. No bubble cycle.
  - Otherwise: go to IDLE, grant_valid=0.
- No release: on a transfer, burst_cnt++; otherwise hold.
- fifo_full=1 in GRANT: no transfer, burst_cnt holds, grant held indefinitely (no timeout).
  - If the owner drops valid while full, release per (b).
- Sole requester: after BURST_LEN transfers it is re-granted with burst_cnt=0 and continues back-to-back.
- BURST_LEN=1: rotation after every transfer.
- grant_id wraps from NUM_REQ-1 to 0 (mod NUM_REQ, not 2^n).
- Requester protocol: once req_valid is asserted, it is held with data stable until ready. The arbiter does not check this; the bench asserts it.
- rst asserted mid-burst: the next cycle is IDLE with all outputs at reset values. A transfer in the rst cycle itself is suppressed (push=0).
- Invariants:
  - $onehot0(req_ready)
  - push -> req_valid[grant_id] & req_ready[grant_id]
  - push never with fifo_full

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, GRANT}
  - function rr_pick(valid vector, start index) returning {found, index}, parameterised through NUM_REQ arguments
- One sub-module, rr_priority_picker (combinational; NUM_REQ param). Inputs: valid vector and start. Outputs: found and index.
- Instantiated once; both IDLE and release paths use it, with start muxed between rr_ptr and grant_id+1.

Test Plan:
- Single requester, BURST_LEN=3: req_valid=4'b0001 held, 7 words, fifo_full=0.
  - grant_valid rises 1 cycle after valid.
  - 7 pushes back-to-back, no bubble; grant_id=0 throughout.
  - burst_cnt resets after push 3 and push 6.
- Four requesters all valid continuously, 12 words each.
  - grant_id sequence 0,1,2,3,0,... with 3 pushes per grant.
  - push_data matches each owner's stream, in order.
- Backpressure: owner 2 mid-burst (burst_cnt=1), fifo_full=1 for 5 cycles.
  - push=0 and req_ready=0 for those 5 cycles; grant_id stays 2.
  - After full drops, exactly 2 more pushes from requester 2, then rotation to 3.
- Early release: owner 1 drops valid after 1 transfer, requesters 0 and 3 valid.
  - Next grant_id=3 (search from 2), no bubble.
  - Then 0 after its burst.
- NUM_REQ=3 wrap, BURST_LEN=1, all valid.
  - grant_id 0,1,2,0,1,2; one push each; grant_id never reaches 3.
- Reset mid-burst: rst=1 for 1 cycle while owner 2 is pushing.
  - That cycle: push=0.
  - Next cycle: grant_valid=0, req_ready=0.
  - Re-arbitration starts from rr_ptr=0, so requester 0 is granted first when valid.
